// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART TX handshake bundle for uart_tx_arbiter.
// The arbiter uses the slave modport. The producers and the TX core use the master modport.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_busy;
  logic [NUM_REQ-1:0]   req_ovf;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 tx_busy;
  logic [2:0]           tx_owner;
  logic                 tx_tmo;

  modport master (
    output req_data, req_ready, tx_busy,
    input  req_busy, req_ovf, tx_data, tx_ready, tx_owner, tx_tmo
  );

  modport slave (
    input  req_data, req_ready, tx_busy,
    output req_busy, req_ovf, tx_data, tx_ready, tx_owner, tx_tmo
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Each producer has a one-byte holding register. Each grant launches one byte with a one-cycle strobe.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_stateNext;
  logic [7:0]           r_hold [NUM_REQ];
  logic [NUM_REQ-1:0]   r_holdValid;
  logic [NUM_REQ-1:0]   w_holdValidNext;
  logic [NUM_REQ-1:0]   r_reqBusy;
  logic [NUM_REQ-1:0]   r_reqOvf;
  logic [7:0]           r_txData;
  logic                 r_txReady;
  logic [2:0]           r_txOwner;
  logic                 r_txTmo;
  logic [7:0]           r_tmoCnt;
  logic [7:0]           w_validPad;
  logic                 w_anyValid;
  logic [2:0]           w_winner;
  logic [7:0]           w_winnerByte;
  logic                 w_launch;
  logic                 w_tmoHit;

  function automatic logic [2:0] wrapIdx(input logic [2:0] owner, input int k);
    int sum;
    sum = int'(owner) + k;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return 3'(sum);
  endfunction

  // Search order is owner+1, owner+2, and so on. Walking backwards lets the nearest pending port win.
  always_comb begin
    w_validPad   = 8'(r_holdValid);
    w_anyValid   = |r_holdValid;
    w_winner     = 3'd0;
    w_winnerByte = 8'h00;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (w_validPad[wrapIdx(r_txOwner, k)]) w_winner = wrapIdx(r_txOwner, k);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == 3'(i)) w_winnerByte = r_hold[i];
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_launch    = 1'b0;
    w_tmoHit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_anyValid && !bus.tx_busy) begin
          w_launch    = 1'b1;
          w_stateNext = ISSUE;
        end
      end
      ISSUE:     w_stateNext = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_stateNext = WAIT_DONE;
        end else if (r_tmoCnt == TMO_LAST) begin
          w_tmoHit    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      WAIT_DONE: if (!bus.tx_busy) w_stateNext = IDLE;
      default:   w_stateNext = IDLE;
    endcase
  end

  // A granted port is freed first. An offer is accepted only into a register that was already empty.
  always_comb begin
    w_holdValidNext = r_holdValid;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_launch && (w_winner == 3'(i))) w_holdValidNext[i] = 1'b0;
      if (bus.req_ready[i] && !r_holdValid[i]) w_holdValidNext[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i] && !r_holdValid[i]) r_hold[i] <= bus.req_data[8*i +: 8];
    end
  end

  // req_busy stays high from the cycle after capture through the cycle the byte is launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_holdValid <= '0;
      r_reqBusy   <= '0;
      r_reqOvf    <= '0;
      r_txData    <= 8'h00;
      r_txReady   <= 1'b0;
      r_txOwner   <= 3'(NUM_REQ - 1);
      r_txTmo     <= 1'b0;
      r_tmoCnt    <= 8'd0;
    end else begin
      r_state     <= w_stateNext;
      r_holdValid <= w_holdValidNext;
      r_reqBusy   <= r_holdValid | w_holdValidNext;
      r_txReady   <= w_launch;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i] && r_holdValid[i]) r_reqOvf[i] <= 1'b1;
      end
      if (w_launch) begin
        r_txData  <= w_winnerByte;
        r_txOwner <= w_winner;
      end
      if (r_state == ISSUE) begin
        r_tmoCnt <= 8'd0;
      end else if ((r_state == WAIT_BUSY) && !bus.tx_busy) begin
        r_tmoCnt <= r_tmoCnt + 8'd1;
      end
      if (w_tmoHit) r_txTmo <= 1'b1;
    end
  end

  assign bus.req_busy = r_reqBusy;
  assign bus.req_ovf  = r_reqOvf;
  assign bus.tx_data  = r_txData;
  assign bus.tx_ready = r_txReady;
  assign bus.tx_owner = r_txOwner;
  assign bus.tx_tmo   = r_txTmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter.
// A transaction-level model is compared against the DUT on every cycle, and hand-computed values pin key moments.
module tb_uart_tx_arbiter;

  localparam int NR  = 2;
  localparam int ACK = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(ACK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs are set for the current cycle. The task then moves to the next falling edge.
  task automatic applyStimulus(input logic [NR-1:0] rdy, input logic [8*NR-1:0] data, input logic busy);
    bus.req_ready = rdy;
    bus.req_data  = data;
    bus.tx_busy   = busy;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_tx_ready", 32'(bus.tx_ready), 0);
    checkOutput("rst_tx_data",  32'(bus.tx_data),  0);
    checkOutput("rst_tx_owner", 32'(bus.tx_owner), NR - 1);
    checkOutput("rst_req_busy", 32'(bus.req_busy), 0);
    checkOutput("rst_req_ovf",  32'(bus.req_ovf),  0);
    checkOutput("rst_tx_tmo",   32'(bus.tx_tmo),   0);
  endtask

  task automatic ack(input int len);
    for (int i = 0; i < len; i++) applyStimulus('0, '0, 1'b1);
    applyStimulus('0, '0, 1'b0);
  endtask

  task automatic waitLaunch(input string tag, input logic [7:0] expData, input logic [2:0] expOwner);
    int n;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 20) begin
      applyStimulus('0, '0, 1'b0);
      n++;
    end
    checkOutput({tag, "_tx_ready"}, 32'(bus.tx_ready), 1);
    checkOutput({tag, "_tx_data"},  32'(bus.tx_data),  32'(expData));
    checkOutput({tag, "_tx_owner"}, 32'(bus.tx_owner), 32'(expOwner));
  endtask

  task automatic expectQuiet(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus('0, '0, 1'b0);
      checkOutput("quiet_tx_ready", 32'(bus.tx_ready), 0);
    end
  endtask

  // Transaction model. It tracks the held bytes, the last owner and the phase of the byte in flight.
  logic [7:0]    mHold [NR];
  logic [NR-1:0] mValid, mOvf, mBusy, oldValid;
  logic [7:0]    mTxData;
  logic          mTxReady, mTmo;
  int            mOwner, mAckLeft, w;
  bit            mLaunchPending, mInTransfer, mLive;
  logic [NR-1:0] sRdy;
  logic [8*NR-1:0] sData;
  logic          sBusy, sReset;

  initial mLive = 1'b0;

  always @(posedge clk) begin
    sRdy   = bus.req_ready;
    sData  = bus.req_data;
    sBusy  = bus.tx_busy;
    sReset = reset;
    if (sReset) begin
      mValid = '0; mOvf = '0; mBusy = '0; mTxData = 8'h00; mTxReady = 1'b0; mTmo = 1'b0;
      mOwner = NR - 1; mAckLeft = 0; mLaunchPending = 1'b0; mInTransfer = 1'b0;
      mLive = 1'b1;
    end else if (mLive) begin
      oldValid = mValid;
      if (mLaunchPending) begin
        mLaunchPending = 1'b0;
        mTxReady = 1'b0;
        mAckLeft = ACK;
      end else if (mAckLeft > 0) begin
        if (sBusy) begin
          mAckLeft = 0;
          mInTransfer = 1'b1;
        end else begin
          mAckLeft--;
          if (mAckLeft == 0) mTmo = 1'b1;
        end
      end else if (mInTransfer) begin
        if (!sBusy) mInTransfer = 1'b0;
      end else if (oldValid != '0 && !sBusy) begin
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          if (w < 0 && oldValid[(mOwner + k) % NR]) w = (mOwner + k) % NR;
        end
        mTxData = mHold[w];
        mOwner = w;
        mValid[w] = 1'b0;
        mTxReady = 1'b1;
        mLaunchPending = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
        if (sRdy[i]) begin
          if (oldValid[i]) mOvf[i] = 1'b1;
          else begin
            mHold[i] = sData[8*i +: 8];
            mValid[i] = 1'b1;
          end
        end
      end
      mBusy = oldValid | mValid;
    end
    #1;
    if (mLive) begin
      checkOutput("m_tx_ready", 32'(bus.tx_ready), 32'(mTxReady));
      checkOutput("m_tx_data",  32'(bus.tx_data),  32'(mTxData));
      checkOutput("m_tx_owner", 32'(bus.tx_owner), 32'(mOwner));
      checkOutput("m_tx_tmo",   32'(bus.tx_tmo),   32'(mTmo));
      checkOutput("m_req_busy", 32'(bus.req_busy), 32'(mBusy));
      checkOutput("m_req_ovf",  32'(bus.req_ovf),  32'(mOvf));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;

    $display("[TB] single byte on port 0");
    doReset();
    applyStimulus(2'b01, 16'h0005, 1'b0);
    checkOutput("t1_busy_T1",  32'(bus.req_busy), 32'h1);
    checkOutput("t1_ready_T1", 32'(bus.tx_ready), 0);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t1_ready_T2", 32'(bus.tx_ready), 1);
    checkOutput("t1_data_T2",  32'(bus.tx_data),  32'h05);
    checkOutput("t1_owner_T2", 32'(bus.tx_owner), 0);
    checkOutput("t1_busy_T2",  32'(bus.req_busy), 32'h1);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t1_ready_T3", 32'(bus.tx_ready), 0);
    checkOutput("t1_busy_T3",  32'(bus.req_busy), 0);
    for (int i = 0; i < 6; i++) applyStimulus('0, '0, 1'b1);
    applyStimulus(2'b10, 16'h6600, 1'b1);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t1_ready_T11", 32'(bus.tx_ready), 0);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t1_ready_T12", 32'(bus.tx_ready), 1);
    checkOutput("t1_data_T12",  32'(bus.tx_data),  32'h66);
    checkOutput("t1_owner_T12", 32'(bus.tx_owner), 1);
    ack(2);

    $display("[TB] simultaneous offers and wrap");
    doReset();
    applyStimulus(2'b11, 16'hB2A1, 1'b0);
    waitLaunch("t2a", 8'hA1, 3'd0);
    ack(3);
    waitLaunch("t2b", 8'hB2, 3'd1);
    ack(3);
    applyStimulus(2'b11, 16'hB2A1, 1'b0);
    waitLaunch("t2c", 8'hA1, 3'd0);
    ack(3);
    waitLaunch("t2d", 8'hB2, 3'd1);
    ack(3);

    $display("[TB] overflow on port 1");
    doReset();
    applyStimulus(2'b01, 16'h00C0, 1'b0);
    applyStimulus(2'b10, 16'hD100, 1'b0);
    checkOutput("t3_ready", 32'(bus.tx_ready), 1);
    checkOutput("t3_data",  32'(bus.tx_data),  32'hC0);
    applyStimulus(2'b10, 16'hE200, 1'b1);
    checkOutput("t3_ovf",  32'(bus.req_ovf),  32'h2);
    checkOutput("t3_busy", 32'(bus.req_busy), 32'h2);
    ack(3);
    waitLaunch("t3b", 8'hD1, 3'd1);
    ack(2);
    expectQuiet(6);

    $display("[TB] acknowledge timeout");
    doReset();
    applyStimulus(2'b11, 16'h2211, 1'b0);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t4_ready", 32'(bus.tx_ready), 1);
    checkOutput("t4_data",  32'(bus.tx_data),  32'h11);
    for (int i = 0; i < ACK; i++) applyStimulus('0, '0, 1'b0);
    checkOutput("t4_tmo_early", 32'(bus.tx_tmo), 0);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t4_tmo_set", 32'(bus.tx_tmo), 1);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t4_ready2", 32'(bus.tx_ready), 1);
    checkOutput("t4_data2",  32'(bus.tx_data),  32'h22);
    checkOutput("t4_owner2", 32'(bus.tx_owner), 1);
    ack(2);
    checkOutput("t4_tmo_sticky", 32'(bus.tx_tmo), 1);

    $display("[TB] tx_busy stuck high in IDLE");
    doReset();
    applyStimulus(2'b01, 16'h005A, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus('0, '0, 1'b1);
    checkOutput("t5_blocked", 32'(bus.tx_ready), 0);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t5_ready", 32'(bus.tx_ready), 1);
    checkOutput("t5_data",  32'(bus.tx_data),  32'h5A);
    ack(2);

    $display("[TB] reset during WAIT_DONE");
    doReset();
    applyStimulus(2'b11, 16'h3C77, 1'b0);
    applyStimulus('0, '0, 1'b0);
    checkOutput("t6_ready", 32'(bus.tx_ready), 1);
    checkOutput("t6_data",  32'(bus.tx_data),  32'h77);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1);
    checkOutput("t6_held", 32'(bus.req_busy), 32'h2);
    reset = 1'b1;
    applyStimulus('0, '0, 1'b1);
    reset = 1'b0;
    checkOutput("t6_rst_ready", 32'(bus.tx_ready), 0);
    checkOutput("t6_rst_busy",  32'(bus.req_busy), 0);
    checkOutput("t6_rst_data",  32'(bus.tx_data),  0);
    checkOutput("t6_rst_owner", 32'(bus.tx_owner), NR - 1);
    expectQuiet(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
